// File: rtl/lsu_bus_ctrl.sv
// M-stage load/store unit: one req/gnt/rvalid access per load/store; 3 cycles for a store with immediate gnt, 4 for a load with rvalid one cycle after gnt.
// Holds stall_o until the bus completes (no backpressure beyond gnt/rvalid). Define LSU_TIMEOUT_EN to abort after TIMEOUT cycles and pulse bus_err_o.
module lsu_bus_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW-1:0]   alu_out_m,
    input  logic [DW-1:0]   write_data_m,
    input  logic [2:0]      func3_m,
    input  logic            mem_write_m,
    input  logic [6:0]      opcode_m,
    output logic            stall_o,
    output logic [DW-1:0]   load_data_o,
    output logic            misaligned_o,
    output logic            bus_err_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [DW-1:0]   bus_addr_o,
    output logic [DW/8-1:0] bus_be_o,
    output logic [DW-1:0]   bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [DW-1:0]   bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state_q, state_d;

    logic            is_load, access, misaligned, accept;
    logic [1:0]      size;
    logic [3:0]      be_d;
    logic [DW-1:0]   wdata_d;

    logic [DW-1:0]   addr_q, wdata_q, load_data_q;
    logic [3:0]      be_q;
    logic            we_q, uns_q;
    logic [1:0]      size_q, off_q;

    logic            stall, mis, capture, abort;
    logic [DW-1:0]   lane, ext;

    assign is_load = (opcode_m == 7'b0000011);
    assign access  = is_load | mem_write_m;

    // size: 0 byte, 1 half, 2 word; func3 3/6/7 fall through to word
    always_comb begin
        size = 2'd2;
        case (func3_m)
            3'd0, 3'd4: size = 2'd0;
            3'd1, 3'd5: size = 2'd1;
            default:    size = 2'd2;
        endcase
    end

    assign misaligned = ((size == 2'd1) && alu_out_m[0]) ||
                        ((size == 2'd2) && (alu_out_m[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (mem_write_m) begin
            case (size)
                2'd0: begin
                    be_d    = 4'b0001 << alu_out_m[1:0];
                    wdata_d = {4{write_data_m[7:0]}};
                end
                2'd1: begin
                    be_d    = 4'b0011 << {alu_out_m[1], 1'b0};
                    wdata_d = {2{write_data_m[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = write_data_m;
                end
            endcase
        end
    end

    // Read data lane selection and sign/zero extension
    assign lane = bus_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ext = lane;
        case (size_q)
            2'd0:    ext = {{(DW-8){lane[7] & ~uns_q}}, lane[7:0]};
            2'd1:    ext = {{(DW-16){lane[15] & ~uns_q}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;
`else
    logic       unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        mis     = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        mis = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        accept  = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_gnt_i) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (bus_rvalid_i) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rvalid_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // pipeline advances this cycle; the same instruction is still in M, so accept nothing
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef LSU_TIMEOUT_EN
        if (((state_q == REQ) || (state_q == WAIT)) && (state_d != DONE) &&
            (cnt_q == 8'(TIMEOUT - 1))) begin
            abort   = 1'b1;
            state_d = DONE;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= {alu_out_m[DW-1:2], 2'b00};
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= mem_write_m;
                uns_q   <= func3_m[2];
                size_q  <= size;
                off_q   <= alu_out_m[1:0];
            end
            if (abort) begin
                load_data_q <= '0;
            end else if (capture) begin
                load_data_q <= ext;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
            if (accept) begin
                cnt_q <= '0;
            end else if ((state_q == REQ) || (state_q == WAIT)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus_err_o = err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    // stall/misaligned are combinational from the M-stage inputs, so gate them off while in reset
    assign stall_o      = stall & ~rst_i;
    assign misaligned_o = mis & ~rst_i;
    assign load_data_o  = load_data_q;
    assign bus_req_o    = (state_q == REQ);
    assign bus_we_o     = we_q;
    assign bus_addr_o   = addr_q;
    assign bus_be_o     = be_q;
    assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized bench for lsu_bus_ctrl: accesses are checked against an arithmetic model of lanes, enables and extension.
// Covers directed cases (store/load lanes, misaligned, gnt wait, reset mid-access, optional timeout) plus random traffic.
module tb_lsu_bus_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] alu_out_m, write_data_m, bus_rdata_i;
    logic [2:0]  func3_m;
    logic        mem_write_m, bus_gnt_i, bus_rvalid_i;
    logic [6:0]  opcode_m;
    logic        stall_o, misaligned_o, bus_err_o, bus_req_o, bus_we_o;
    logic [31:0] load_data_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_ld = 32'd0;

    bit          r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd, r_rd;
    int          r_gd, r_rdly;
    int          to_reqs;
    bit          to_seen;

    always #5 clk_i = ~clk_i;

    lsu_bus_ctrl #(.DW(32), .TIMEOUT(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .func3_m      (func3_m),
        .mem_write_m  (mem_write_m),
        .opcode_m     (opcode_m),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .misaligned_o (misaligned_o),
        .bus_err_o    (bus_err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (!st) return 4'hF;
        return 4'(((1 << nbytes(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (nbytes(f3))
            1:       return 32'(wd[7:0]) * 32'h0101_0101;
            2:       return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int          nb;
        logic [31:0] mask, v;
        nb   = nbytes(f3);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = (rd >> (8 * (a % 4))) & mask;
        if (((f3 == 3'd0) || (f3 == 3'd1)) && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        opcode_m     = 7'b0010011;
        mem_write_m  = 1'b0;
        func3_m      = 3'd0;
        alu_out_m    = 32'd0;
        write_data_m = 32'd0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask

    task automatic present(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        opcode_m     = st ? 7'b0100011 : 7'b0000011;
        mem_write_m  = st;
        func3_m      = f3;
        alu_out_m    = a;
        write_data_m = wd;
    endtask

    // One access; gd = REQ cycles before gnt, rdly = cycles from gnt to rvalid (0 = same cycle)
    task automatic do_access(input string tag, input bit st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int gd, input int rdly);
        int          stalls, reqs, gnt_cyc, exp_stalls;
        bit          done;
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;
        ebe        = m_be(st, f3, a);
        ewd        = m_wdata(f3, wd);
        eaddr      = a & 32'hFFFF_FFFC;
        exp_stalls = 2 + gd + (st ? 0 : rdly);
        if (!st) exp_ld = m_load(f3, a, rd);
        stalls  = 1;
        reqs    = 0;
        gnt_cyc = -1;
        done    = 1'b0;
        @(posedge clk_i); #1;
        present(st, f3, a, wd);
        #1;
        chk({tag, "/idle_stall"}, 32'(stall_o), 32'd1);
        chk({tag, "/idle_req"}, 32'(bus_req_o), 32'd0);
        chk({tag, "/idle_mis"}, 32'(misaligned_o), 32'd0);
        for (int c = 1; c <= 100 && !done; c++) begin
            @(posedge clk_i); #1;
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = $urandom;
            if (bus_req_o && gnt_cyc < 0) begin
                if (reqs == gd) begin
                    bus_gnt_i = 1'b1;
                    gnt_cyc   = c;
                end
                reqs++;
            end
            if (!st && gnt_cyc >= 0 && c == gnt_cyc + rdly) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = rd;
            end
            #1;
            if (bus_req_o) begin
                chk({tag, "/addr"}, bus_addr_o, eaddr);
                chk({tag, "/be"}, 32'(bus_be_o), 32'(ebe));
                chk({tag, "/we"}, 32'(bus_we_o), 32'(st));
                if (st) chk({tag, "/wdata"}, bus_wdata_o, ewd);
            end
            if (!stall_o) done = 1'b1;
            else stalls++;
        end
        chk({tag, "/completed"}, 32'(done), 32'd1);
        chk({tag, "/stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({tag, "/done_req"}, 32'(bus_req_o), 32'd0);
        chk({tag, "/load_data"}, load_data_o, exp_ld);
        chk({tag, "/err"}, 32'(bus_err_o), 32'd0);
        idle_inputs();
    endtask

    task automatic do_misaligned(input string tag, input bit st, input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk_i); #1;
        present(st, f3, a, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk({tag, "/mis"}, 32'(misaligned_o), 32'd1);
            chk({tag, "/stall"}, 32'(stall_o), 32'd0);
            chk({tag, "/req"}, 32'(bus_req_o), 32'd0);
            @(posedge clk_i); #1;
        end
        idle_inputs();
        #1;
        chk({tag, "/mis_clear"}, 32'(misaligned_o), 32'd0);
        chk({tag, "/ld_kept"}, load_data_o, exp_ld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        bus_rdata_i = 32'd0;
        idle_inputs();
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst/stall", 32'(stall_o), 32'd0);
        chk("rst/load_data", load_data_o, 32'd0);
        chk("rst/mis", 32'(misaligned_o), 32'd0);
        chk("rst/err", 32'(bus_err_o), 32'd0);
        chk("rst/req", 32'(bus_req_o), 32'd0);
        chk("rst/we", 32'(bus_we_o), 32'd0);
        chk("rst/addr", bus_addr_o, 32'd0);
        chk("rst/be", 32'(bus_be_o), 32'd0);
        chk("rst/wdata", bus_wdata_o, 32'd0);
        @(negedge clk_i) rst_i = 1'b0;

        do_access("sw", 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 0);
        do_access("sb", 1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'd0, 0, 0);
        do_access("lb", 1'b0, 3'd0, 32'h102, 32'd0, 32'h0080_0000, 0, 3);
        chk("lb/value", load_data_o, 32'hFFFF_FF80);
        do_access("lbu", 1'b0, 3'd4, 32'h102, 32'd0, 32'h0080_0000, 0, 3);
        chk("lbu/value", load_data_o, 32'h0000_0080);
        do_misaligned("lh_mis", 1'b0, 3'd1, 32'h101);
        do_access("lw_fast", 1'b0, 3'd2, 32'h104, 32'd0, 32'h1234_5678, 0, 0);
        chk("lw_fast/value", load_data_o, 32'h1234_5678);
        do_access("sh_gnt4", 1'b1, 3'd1, 32'h202, 32'hCAFE_1234, 32'd0, 4, 0);

`ifdef LSU_TIMEOUT_EN
        to_reqs = 0;
        to_seen = 1'b0;
        @(posedge clk_i); #1;
        present(1'b0, 3'd2, 32'h300, 32'd0);
        for (int c = 0; c < 40 && !to_seen; c++) begin
            @(posedge clk_i); #2;
            if (bus_req_o) begin
                to_reqs++;
            end else begin
                to_seen = 1'b1;
                chk("to/req_cycles", 32'(to_reqs), 32'd16);
                chk("to/err", 32'(bus_err_o), 32'd1);
                chk("to/load_data", load_data_o, 32'd0);
                chk("to/stall", 32'(stall_o), 32'd0);
            end
        end
        chk("to/aborted", 32'(to_seen), 32'd1);
        idle_inputs();
        exp_ld = 32'd0;
        @(posedge clk_i); #2;
        chk("to/err_clear", 32'(bus_err_o), 32'd0);
        chk("to/idle_stall", 32'(stall_o), 32'd0);
`endif

        // reset asserted while waiting for rvalid
        @(posedge clk_i); #1;
        present(1'b0, 3'd2, 32'h400, 32'd0);
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b1;
        #1;
        chk("rstw/req", 32'(bus_req_o), 32'd1);
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b0;
        #1;
        chk("rstw/wait_stall", 32'(stall_o), 32'd1);
        chk("rstw/wait_req", 32'(bus_req_o), 32'd0);
        rst_i = 1'b1;
        #1;
        chk("rstw/stall_drop", 32'(stall_o), 32'd0);
        chk("rstw/req_drop", 32'(bus_req_o), 32'd0);
        chk("rstw/ld_cleared", load_data_o, 32'd0);
        idle_inputs();
        exp_ld = 32'd0;
        @(negedge clk_i) rst_i = 1'b0;
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h5555_AAAA;
        #1;
        chk("rstw/late_stall", 32'(stall_o), 32'd0);
        chk("rstw/late_req", 32'(bus_req_o), 32'd0);
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
        #1;
        chk("rstw/late_ignored", load_data_o, 32'd0);

        for (int i = 0; i < 40; i++) begin
            r_st   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, r_st ? 2 : 7));
            r_a    = 32'h1000 + ($urandom & 32'hFF);
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_gd   = int'($urandom_range(0, 3));
            r_rdly = int'($urandom_range(0, 3));
            if ((r_a % nbytes(r_f3)) != 0)
                do_misaligned("rnd_mis", r_st, r_f3, r_a);
            else
                do_access("rnd", r_st, r_f3, r_a, r_wd, r_rd, r_gd, r_rdly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
